// File: rtl/muxn_pkg.sv
// muxn_pkg: shared types for the registered M:1 selector.
// Skid state encoding and default error counter width.
package muxn_pkg;

  localparam int ERR_CNT_W = 16;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL1 = 2'd1,
    FULL2 = 2'd2
  } skid_state_e;

endpackage

// File: rtl/muxn_reg_stage_skid_reg2.sv
// skid_reg2: 2-entry valid/ready skid register, W-bit payload.
// Ports: clk, rst, in_* (upstream handshake), out_* (downstream handshake).
module skid_reg2
  import muxn_pkg::*;
#(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);

  skid_state_e  state_q, state_d;
  logic [W-1:0] out_q, out_d;
  logic [W-1:0] skid_q, skid_d;
  logic         acc, drn;

  // ready/valid depend on the state register only
  assign in_ready  = (state_q != FULL2);
  assign out_valid = (state_q != EMPTY);
  assign out_data  = out_q;

  assign acc = in_valid && in_ready;
  assign drn = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    unique case (state_q)
      EMPTY: begin
        if (acc) begin
          out_d   = in_data;
          state_d = FULL1;
        end
      end
      FULL1: begin
        if (acc && drn) begin
          out_d = in_data;
        end else if (acc) begin
          skid_d  = in_data;
          state_d = FULL2;
        end else if (drn) begin
          state_d = EMPTY;
        end
      end
      FULL2: begin
        if (drn) begin
          out_d   = skid_q;
          state_d = FULL1;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      out_q   <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: rtl/muxn_reg_stage.sv
// muxn_reg_stage: M:1 word select into a skid-buffered output stage.
// Ports: in_data/in_sel/in_valid/in_ready, out_data/out_sel_err/
// out_valid/out_ready, err_count (saturating out-of-range count).
module muxn_reg_stage
  import muxn_pkg::*;
#(
  parameter  int N         = 32,
  parameter  int M         = 3,
  parameter  int ERR_CNT_W = muxn_pkg::ERR_CNT_W,
  localparam int SELW      = $clog2(M)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [M*N-1:0]       in_data,
  input  logic [SELW-1:0]      in_sel,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [N-1:0]         out_data,
  output logic                 out_sel_err,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ERR_CNT_W-1:0] err_count
);

  typedef struct packed {
    logic [N-1:0] data;
    logic         sel_err;
  } beat_t;

  localparam int BW = $bits(beat_t);

  beat_t                sel_beat;
  beat_t                out_beat;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  // unmatched select falls through as zero data with sel_err set
  always_comb begin
    sel_beat         = '0;
    sel_beat.sel_err = 1'b1;
    for (int k = 0; k < M; k++) begin
      if (int'(in_sel) == k) begin
        sel_beat.data    = in_data[k*N +: N];
        sel_beat.sel_err = 1'b0;
      end
    end
  end

  skid_reg2 #(
    .W(BW)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .in_data  (sel_beat),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_beat),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  assign out_data    = out_beat.data;
  assign out_sel_err = out_beat.sel_err;

  // counted on acceptance, saturating at all-ones
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (in_valid && in_ready && sel_beat.sel_err
        && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_count = err_cnt_q;

endmodule

// File: tb/tb_muxn_reg_stage.sv
// tb_muxn_reg_stage: random + directed bench against a queue model.
// Covers M=3 main, 4-bit saturating counter and M=4 variants.
module tb_muxn_reg_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic [95:0] in_data = '0;
  logic [1:0]  in_sel = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_sel_err;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] err_count;

  logic [23:0] s_in_data = '0;
  logic [1:0]  s_in_sel = '0;
  logic        s_in_valid = 1'b0;
  logic        s_in_ready;
  logic [7:0]  s_out_data;
  logic        s_out_sel_err;
  logic        s_out_valid;
  logic        s_out_ready = 1'b1;
  logic [3:0]  s_err_count;

  logic [31:0] p_in_data = '0;
  logic [1:0]  p_in_sel = '0;
  logic        p_in_valid = 1'b0;
  logic        p_in_ready;
  logic [7:0]  p_out_data;
  logic        p_out_sel_err;
  logic        p_out_valid;
  logic        p_out_ready = 1'b1;
  logic [15:0] p_err_count;

  int n_tests = 0;
  int n_fail = 0;

  logic [31:0] w [3];
  logic [32:0] q [$];
  int          exp_err = 0;

  always #5 clk = ~clk;

  muxn_reg_stage #(.N(32), .M(3)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_sel(in_sel),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_sel_err(out_sel_err),
    .out_valid(out_valid), .out_ready(out_ready),
    .err_count(err_count)
  );

  muxn_reg_stage #(.N(8), .M(3), .ERR_CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst),
    .in_data(s_in_data), .in_sel(s_in_sel),
    .in_valid(s_in_valid), .in_ready(s_in_ready),
    .out_data(s_out_data), .out_sel_err(s_out_sel_err),
    .out_valid(s_out_valid), .out_ready(s_out_ready),
    .err_count(s_err_count)
  );

  muxn_reg_stage #(.N(8), .M(4)) dut_p2 (
    .clk(clk), .rst(rst),
    .in_data(p_in_data), .in_sel(p_in_sel),
    .in_valid(p_in_valid), .in_ready(p_in_ready),
    .out_data(p_out_data), .out_sel_err(p_out_sel_err),
    .out_valid(p_out_valid), .out_ready(p_out_ready),
    .err_count(p_err_count)
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One cycle on the main instance: drive at negedge, compare
  // against the queue model, then advance the model at the edge.
  task automatic cyc(input logic v, input logic [1:0] s,
                     input logic ordy);
    logic        acc, drn;
    logic [32:0] beat;
    in_data   = {w[2], w[1], w[0]};
    in_valid  = v;
    in_sel    = s;
    out_ready = ordy;
    #1;
    check("in_ready", 64'(in_ready), 64'(q.size() < 2));
    check("out_valid", 64'(out_valid), 64'(q.size() > 0));
    if (q.size() > 0) begin
      check("out_data", 64'(out_data), 64'(q[0][31:0]));
      check("out_sel_err", 64'(out_sel_err), 64'(q[0][32]));
    end
    check("err_count", 64'(err_count), 64'(exp_err));
    acc  = v && (q.size() < 2);
    drn  = (q.size() > 0) && ordy;
    beat = (s < 3) ? {1'b0, w[s]} : {1'b1, 32'h0};
    @(posedge clk);
    if (drn) void'(q.pop_front());
    if (acc) begin
      q.push_back(beat);
      if (s == 2'd3 && exp_err < 65535) exp_err++;
    end
    @(negedge clk);
  endtask

  initial begin
    w[0] = 32'hAAAAAAAA;
    w[1] = 32'h55555555;
    w[2] = 32'hFFFFFFFF;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_sel_err", 64'(out_sel_err), 64'd0);
    check("rst_err_count", 64'(err_count), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    rst = 1'b0;

    // back-to-back selects 0..3
    for (int i = 0; i < 4; i++) cyc(1'b1, 2'(i), 1'b1);
    cyc(1'b0, 2'd0, 1'b1);
    cyc(1'b0, 2'd0, 1'b1);
    check("err_after_seq", 64'(err_count), 64'd1);

    // backpressure: third beat held off until drain
    cyc(1'b1, 2'd0, 1'b0);
    cyc(1'b1, 2'd1, 1'b0);
    cyc(1'b1, 2'd2, 1'b0);
    cyc(1'b1, 2'd2, 1'b0);
    cyc(1'b1, 2'd2, 1'b1);
    cyc(1'b1, 2'd2, 1'b1);
    cyc(1'b0, 2'd0, 1'b1);
    cyc(1'b0, 2'd0, 1'b1);

    // sustained accept+drain in FULL1
    cyc(1'b1, 2'd1, 1'b1);
    for (int i = 0; i < 10; i++) begin
      for (int k = 0; k < 3; k++) w[k] = $urandom;
      cyc(1'b1, 2'($urandom_range(0, 2)), 1'b1);
    end
    cyc(1'b0, 2'd0, 1'b1);

    // random traffic
    for (int i = 0; i < 300; i++) begin
      for (int k = 0; k < 3; k++) w[k] = $urandom;
      cyc(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
          1'($urandom_range(0, 3) != 0));
    end

    // reset while two beats are stored
    cyc(1'b0, 2'd0, 1'b1);
    cyc(1'b0, 2'd0, 1'b1);
    cyc(1'b1, 2'd1, 1'b0);
    cyc(1'b1, 2'd3, 1'b0);
    in_valid  = 1'b1;
    in_sel    = 2'd3;
    out_ready = 1'b1;
    rst       = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_out_data", 64'(out_data), 64'd0);
    check("mid_rst_sel_err", 64'(out_sel_err), 64'd0);
    check("mid_rst_err_count", 64'(err_count), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd1);
    q.delete();
    exp_err = 0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) cyc(1'b0, 2'd0, 1'b1);
    in_valid = 1'b0;

    // 4-bit counter saturates at 15
    s_in_data  = 24'h332211;
    s_in_sel   = 2'd3;
    s_in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      check("sat_err_count", 64'(s_err_count),
            64'((i + 1 > 15) ? 15 : i + 1));
      check("sat_out_sel_err", 64'(s_out_sel_err), 64'd1);
      check("sat_out_data", 64'(s_out_data), 64'd0);
      @(negedge clk);
    end
    s_in_valid = 1'b0;

    // M=4: every select is in range
    for (int i = 0; i < 8; i++) begin
      logic [7:0] pw [4];
      for (int k = 0; k < 4; k++) pw[k] = 8'($urandom);
      p_in_data  = {pw[3], pw[2], pw[1], pw[0]};
      p_in_sel   = 2'(i % 4);
      p_in_valid = 1'b1;
      @(posedge clk);
      #1;
      check("p2_out_valid", 64'(p_out_valid), 64'd1);
      check("p2_out_data", 64'(p_out_data), 64'(pw[i % 4]));
      check("p2_sel_err", 64'(p_out_sel_err), 64'd0);
      check("p2_err_count", 64'(p_err_count), 64'd0);
      @(negedge clk);
    end
    p_in_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/muxn_reg_stage.md
# muxn_reg_stage

Parametrised M:1 word selector with a registered, valid/ready-handshaked output stage; the pipelined successor to the combinational 3:1 operand/result mux. Sits between producer stages (ALU, load unit, PC+4) and the writeback or forwarding path of the pipelined core. Adds backpressure tolerance through a 2-entry skid buffer, flags out-of-range selects and counts them. Out-of-range selects yield zero data, matching the combinational mux's default case.

## Interface
- N, 32, data width in bits (≥1)
- M, 3, number of input words (≥2)
- SELW, $clog2(M), select width (derived, not overridden)
- ERR_CNT_W, 16, error counter width (from package)

- clk  in  1  rising-edge clock; only clock
- rst  in  1  synchronous, active-high reset
- in_data  in  M*N  flattened inputs; word k = in_data[k*N +: N]
- in_sel  in  SELW  binary select
- in_valid  in  1  producer offers in_data/in_sel
- in_ready  out  1  stage can accept
- out_data  out  N  selected word
- out_sel_err  out  1  travels with out_data; 1 = select was ≥ M
- out_valid  out  1  out_data/out_sel_err valid
- out_ready  in  1  consumer accepts
- err_count  out  ERR_CNT_W  saturating count of accepted out-of-range selects

## Operation
- Accept: in_valid && in_ready at rising edge. Drain: out_valid && out_ready.
- Selected word: in_data word in_sel if in_sel < M; else all-zero data with sel_err=1.
- Storage: output register (OUT) plus skid register (SKID). States (package enum):
  - EMPTY: out_valid=0, in_ready=1. Accept → load OUT, go FULL1.
  - FULL1: out_valid=1, in_ready=1. Accept & drain → reload OUT, stay. Accept only → load SKID, go FULL2. Drain only → EMPTY. Neither → hold.
  - FULL2: out_valid=1, in_ready=0. Drain → OUT←SKID, go FULL1. Otherwise hold.
- in_ready is a decode of the state register only (no combinational path from out_ready).
- out_data/out_sel_err stable while out_valid=1 and out_ready=0.
- Order preserved: words leave in acceptance order; no drop, no duplication.
- err_count increments by 1 on each accepted beat with in_sel ≥ M; saturates at all-ones. Counted at acceptance, not drain.
- When M is a power of two, out-of-range is impossible; sel_err and err_count stay 0.

## Timing
- Reset values: state EMPTY, out_valid=0, out_data=0, out_sel_err=0, err_count=0, in_ready=1 (from first cycle after rst sampled high; also while rst high).
- Latency: beat accepted at edge t appears on out_* after edge t (visible cycle t+1), when storage was EMPTY or drained that edge.
- Throughput: 1 beat/cycle sustained with out_ready=1.
- Backpressure: after out_ready falls, at most one further beat accepted (into SKID); in_ready low the following cycle.
- Simultaneous accept and drain in FULL1: OUT takes new word, SKID untouched.
- Reset mid-operation: OUT and SKID contents discarded, counter cleared; rst dominates any concurrent accept/drain.
- Counter at max with another error: stays at max, no wrap.

## Structure
- Package muxn_pkg: state enum (EMPTY, FULL1, FULL2), ERR_CNT_W=16 constant, beat struct {data, sel_err} parametrised via localparam in the consumer.
- Sub-module skid_reg2: generic 2-entry valid/ready skid register on a payload of width N+1; muxn_reg_stage = combinational select + skid_reg2 + error counter.

## Test plan
- N=32, M=3; words a=AAAAAAAA, b=55555555, c=FFFFFFFF; out_ready=1; sel 0,1,2,3 back-to-back → out_data AAAAAAAA, 55555555, FFFFFFFF, 00000000 on consecutive cycles, each 1 cycle after accept; sel_err 0,0,0,1; err_count=1.
- Backpressure: out_ready=0, stream sel 0,1,2 → in_ready falls after 2nd accept; out holds AAAAAAAA; raise out_ready → AAAAAAAA, 55555555 drained, then 3rd accepted and delivered; no loss/reorder.
- Simultaneous accept+drain in FULL1 for 10 cycles with random sel<3 → output equals scoreboard, state stays FULL1.
- Saturation: ERR_CNT_W forced to 4 variant, 20 accepted sel=3 → err_count=15 held.
- Reset mid-operation: FULL2 with two beats, assert rst 1 cycle → out_valid=0, out_data=0, err_count=0, in_ready=1; no stale beat emerges.
- M=4: sel 0..3 → all in range, sel_err=0, err_count=0.
